// File: rtl/eeprom_i2c_slave.sv
// Two-wire serial EEPROM responder: 2**ADDR_W x 8 memory behind START/STOP, control,
// word-address and data-byte decoding, with open-drain ACK and read-data drive on SDA.
module eeprom_i2c_slave #(
  parameter int unsigned ADDR_W = 11,
  parameter logic [3:0]  DEV_ID = 4'b1010,
  parameter int unsigned SYNC   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              BUSY,
  output logic              WR_EVT,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA
);

  // Upper address bits come from control byte bits [HI_W:1]; valid for ADDR_W 9..11.
  localparam int unsigned HI_W  = ADDR_W - 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  logic [SYNC-1:0]   scl_sync, sda_sync;
  logic              scl_d, sda_d;
  logic              scl_s, sda_s;
  logic              scl_rise, scl_fall, start_det, stop_det;

  state_t            state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic [ADDR_W-1:0] addr_ptr, addr_nxt;
  logic              rw, rw_nxt;
  logic              sda_oe, sda_oe_nxt;
  logic              busy_nxt;
  logic              wr_evt_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic              mem_we;
  logic [7:0]        byte_in;
  logic [7:0]        mem_rd;

  logic [7:0]        mem [DEPTH];

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  assign scl_s     = scl_sync[SYNC-1];
  assign sda_s     = sda_sync[SYNC-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign mem_rd = mem[addr_ptr];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC-2:0], SCL};
      sda_sync <= {sda_sync[SYNC-2:0], SDA};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      addr_ptr <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      BUSY     <= 1'b0;
      WR_EVT   <= 1'b0;
      WR_ADDR  <= '0;
      WR_DATA  <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      addr_ptr <= addr_nxt;
      rw       <= rw_nxt;
      sda_oe   <= sda_oe_nxt;
      BUSY     <= busy_nxt;
      WR_EVT   <= wr_evt_nxt;
      WR_ADDR  <= wr_addr_nxt;
      WR_DATA  <= wr_data_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[addr_ptr] <= byte_in;
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    addr_nxt    = addr_ptr;
    rw_nxt      = rw;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = BUSY;
    wr_evt_nxt  = 1'b0;
    wr_addr_nxt = WR_ADDR;
    wr_data_nxt = WR_DATA;
    mem_we      = 1'b0;
    byte_in     = {shreg[6:0], sda_s};

    if (start_det) begin
      state_nxt   = CTRL;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b1;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        CTRL, ADDR, WDATA: begin
          if (scl_rise) begin
            shreg_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = '0;
              if (state == CTRL) begin
                if (byte_in[7:4] != DEV_ID) begin
                  state_nxt = WAIT_STOP;
                end else begin
                  addr_nxt[ADDR_W-1:8] = byte_in[HI_W:1];
                  rw_nxt               = byte_in[0];
                  state_nxt            = CTRL_ACK;
                end
              end else if (state == ADDR) begin
                state_nxt = ADDR_ACK;
              end else begin
                mem_we      = 1'b1;
                wr_evt_nxt  = 1'b1;
                wr_addr_nxt = addr_ptr;
                wr_data_nxt = byte_in;
                state_nxt   = WDATA_ACK;
              end
            end
          end
        end

        // ACK states are entered on the 8th rise: first fall starts the drive, second ends it.
        CTRL_ACK, ADDR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_nxt  = 1'b1;
              bit_cnt_nxt = 4'd1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              if (state == CTRL_ACK) begin
                if (rw) begin
                  state_nxt   = RDATA;
                  shreg_nxt   = mem_rd;
                  sda_oe_nxt  = ~mem_rd[7];
                  bit_cnt_nxt = 4'd1;
                end else begin
                  state_nxt = ADDR;
                end
              end else if (state == ADDR_ACK) begin
                addr_nxt[7:0] = shreg;
                state_nxt     = WDATA;
              end else begin
                addr_nxt  = addr_ptr + 1'b1;
                state_nxt = WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = RACK;
            end else begin
              sda_oe_nxt  = ~shreg[6];
              shreg_nxt   = {shreg[6:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end

        // Master ACK is sampled on the rise; the next byte is loaded on the following fall
        // so that mem_rd already sees the incremented pointer.
        RACK: begin
          if (scl_rise && bit_cnt == 4'd0) begin
            addr_nxt = addr_ptr + 1'b1;
            if (sda_s) state_nxt = WAIT_STOP;
            else       bit_cnt_nxt = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_nxt   = RDATA;
            shreg_nxt   = mem_rd;
            sda_oe_nxt  = ~mem_rd[7];
            bit_cnt_nxt = 4'd1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Bench for eeprom_i2c_slave: bit-banged two-wire master, vector table, directed corner
// sequences and randomized transactions checked against an array-based memory model.
module tb_eeprom_i2c_slave;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        SCL = 1'b1;
  logic        m_sda = 1'b1;
  wire         SDA;
  logic        BUSY, WR_EVT;
  logic [10:0] WR_ADDR;
  logic [7:0]  WR_DATA;

  int checks = 0;
  int errors = 0;

  assign SDA = m_sda ? 1'bz : 1'b0;
  pullup (SDA);

  always #5 CLK = ~CLK;

  eeprom_i2c_slave #(.ADDR_W(11), .DEV_ID(4'b1010), .SYNC(2)) dut (
    .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA(SDA), .BUSY(BUSY),
    .WR_EVT(WR_EVT), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  // Observers
  logic [18:0] evq[$];
  int          dut_low = 0;
  always @(negedge CLK) begin
    if (WR_EVT === 1'b1) evq.push_back({WR_ADDR, WR_DATA});
    if (SDA === 1'b0 && m_sda) dut_low++;
  end

  // Reference model
  logic [7:0]  mmem [2048];
  bit          mval [2048];
  logic [10:0] mptr = '0;
  logic [10:0] waddrs[$];

  logic [7:0]  wbuf [4];
  logic [7:0]  rbuf [4];

  typedef struct {
    logic [3:0]  id;
    logic [10:0] addr;
    logic [7:0]  data;
    int          exp_acks;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic hq();
    repeat (5) @(negedge CLK);
  endtask

  task automatic clk_bit(output logic smp);
    hq(); SCL = 1'b1; hq(); smp = SDA; hq(); SCL = 1'b0; hq();
  endtask

  task automatic bus_start();
    m_sda = 1'b1; hq(); SCL = 1'b1; hq(); m_sda = 1'b0; hq(); SCL = 1'b0; hq();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; hq(); SCL = 1'b1; hq(); m_sda = 1'b1; hq(); hq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i];
      clk_bit(s);
    end
    m_sda = 1'b1;
    clk_bit(s);
    ack = (s === 1'b0);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1;
      clk_bit(s);
      d = {d[6:0], (s === 1'b0) ? 1'b0 : 1'b1};
    end
    m_sda = nack;
    clk_bit(s);
    m_sda = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [10:0] a, input int n,
                          output int acks);
    logic ok;
    acks = 0;
    bus_start();
    chk("busy_after_start", 32'(BUSY), 32'd1);
    send_byte({id, a[10:8], 1'b0}, ok);
    if (ok) begin
      acks++;
      send_byte(a[7:0], ok);
      if (ok) acks++;
      for (int i = 0; i < n; i++) begin
        send_byte(wbuf[i], ok);
        if (ok) acks++;
      end
    end
    bus_stop();
  endtask

  task automatic do_rread(input logic [10:0] a, input int n, output int acks);
    logic ok;
    acks = 0;
    bus_start();
    send_byte({4'hA, a[10:8], 1'b0}, ok); if (ok) acks++;
    send_byte(a[7:0], ok);                if (ok) acks++;
    bus_start();
    send_byte({4'hA, a[10:8], 1'b1}, ok); if (ok) acks++;
    for (int i = 0; i < n; i++) recv_byte(rbuf[i], (i == n - 1));
    bus_stop();
  endtask

  task automatic do_cread(input logic [2:0] hi, input int n, output int acks);
    logic ok;
    acks = 0;
    bus_start();
    send_byte({4'hA, hi, 1'b1}, ok); if (ok) acks++;
    for (int i = 0; i < n; i++) recv_byte(rbuf[i], (i == n - 1));
    bus_stop();
  endtask

  task automatic model_write(input logic [10:0] a, input int n);
    logic [10:0] ea;
    for (int i = 0; i < n; i++) begin
      ea = a + 11'(i);
      mmem[ea] = wbuf[i];
      mval[ea] = 1'b1;
    end
    waddrs.push_back(a);
    mptr = a + 11'(n);
  endtask

  task automatic check_events(input string nm, input logic [10:0] a, input int n);
    logic [10:0] ea;
    chk({nm, "_evt_count"}, 32'(evq.size()), 32'(n));
    for (int i = 0; i < n && i < evq.size(); i++) begin
      ea = a + 11'(i);
      chk($sformatf("%s_evt%0d", nm, i), 32'(evq[i]), {13'd0, ea, wbuf[i]});
    end
    evq.delete();
  endtask

  task automatic check_reads(input string nm, input logic [10:0] a, input int n);
    logic [10:0] ea;
    for (int i = 0; i < n; i++) begin
      ea = a + 11'(i);
      if (mval[ea]) chk($sformatf("%s_rd%0d@%0h", nm, i, ea), 32'(rbuf[i]), 32'(mmem[ea]));
    end
    mptr = a + 11'(n);
  endtask

  int          acks, low0, n, op;
  logic [10:0] a;
  logic        ok, s;

  initial begin
    tbl[0] = '{4'hA, 11'h3C7, 8'h5A, 3};
    tbl[1] = '{4'h9, 11'h000, 8'h00, 0};
    tbl[2] = '{4'hA, 11'h100, 8'h3E, 3};
    tbl[3] = '{4'hA, 11'h310, 8'h77, 3};
    tbl[4] = '{4'h5, 11'h7FF, 8'hFF, 0};
    tbl[5] = '{4'hA, 11'h0AA, 8'hC3, 3};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy",    32'(BUSY),    32'd0);
    chk("rst_wr_evt",  32'(WR_EVT),  32'd0);
    chk("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    chk("rst_wr_data", 32'(WR_DATA), 32'd0);
    chk("rst_sda_released", 32'(SDA === 1'b0), 32'd0);
    RESET = 1'b1;
    hq();

    // Table of single-byte writes (incl. wrong device IDs)
    for (int t = 0; t < 6; t++) begin
      low0 = dut_low;
      wbuf[0] = tbl[t].data;
      do_write(tbl[t].id, tbl[t].addr, 1, acks);
      chk($sformatf("vec%0d_acks", t), 32'(acks), 32'(tbl[t].exp_acks));
      chk($sformatf("vec%0d_busy_after_stop", t), 32'(BUSY), 32'd0);
      if (tbl[t].exp_acks != 0) begin
        check_events($sformatf("vec%0d", t), tbl[t].addr, 1);
        model_write(tbl[t].addr, 1);
      end else begin
        check_events($sformatf("vec%0d", t), tbl[t].addr, 0);
        chk($sformatf("vec%0d_sda_never_low", t), 32'(dut_low - low0), 32'd0);
      end
    end

    // Random-read each written location back
    for (int t = 0; t < 6; t++) begin
      if (tbl[t].exp_acks != 0) begin
        do_rread(tbl[t].addr, 1, acks);
        chk($sformatf("rb%0d_acks", t), 32'(acks), 32'd3);
        check_reads($sformatf("rb%0d", t), tbl[t].addr, 1);
        chk($sformatf("rb%0d_sda_released", t), 32'(SDA === 1'b0), 32'd0);
      end
    end

    // Address wrap on write and read
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(4'hA, 11'h7FF, 2, acks);
    chk("wrap_wr_acks", 32'(acks), 32'd4);
    check_events("wrap_wr", 11'h7FF, 2);
    model_write(11'h7FF, 2);
    chk("wrap_ptr_model", 32'(mptr), 32'h001);
    do_rread(11'h7FF, 2, acks);
    chk("wrap_rd_acks", 32'(acks), 32'd3);
    chk("wrap_rd0", 32'(rbuf[0]), 32'h11);
    chk("wrap_rd1", 32'(rbuf[1]), 32'h22);
    mptr = 11'h001;

    // Abort a write after 5 data bits
    bus_start();
    send_byte(8'hA6, ok);
    send_byte(8'h10, s);
    chk("abort_hdr_acks", 32'({ok, s}), 32'h3);
    for (int i = 0; i < 5; i++) begin
      m_sda = i[0];
      clk_bit(s);
    end
    bus_stop();
    mptr = 11'h310;
    check_events("abort", 11'h310, 0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    do_cread(mptr[10:8], 1, acks);
    chk("abort_cread_acks", 32'(acks), 32'd1);
    check_reads("abort_cread", mptr, 1);

    // Reset while the slave drives a 0 read bit (mem[0x3C7] = 0x5A, MSB 0)
    bus_start();
    send_byte(8'hA6, ok);
    send_byte(8'hC7, ok);
    bus_start();
    send_byte(8'hA7, ok);
    chk("rstmid_ctrl_ack", 32'(ok), 32'd1);
    chk("rstmid_bit7_driven", 32'(SDA === 1'b0), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rstmid_sda_released", 32'(SDA === 1'b0), 32'd0);
    chk("rstmid_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    SCL = 1'b1; hq();
    m_sda = 1'b1; hq();
    RESET = 1'b1; hq(); hq();
    mptr = '0;
    do_cread(3'd0, 1, acks);
    chk("rstmid_cread_acks", 32'(acks), 32'd1);
    check_reads("rstmid_cread", 11'h000, 1);

    // Randomized transactions against the model
    for (int t = 0; t < 12; t++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        a = ($urandom_range(0, 3) == 0) ? 11'(11'h7FC + 11'($urandom_range(0, 3)))
                                        : 11'($urandom_range(0, 2047));
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
        do_write(4'hA, a, n, acks);
        chk($sformatf("rnd%0d_wr_acks", t), 32'(acks), 32'(n + 2));
        check_events($sformatf("rnd%0d", t), a, n);
        model_write(a, n);
      end else if (op == 1) begin
        a = waddrs[$urandom_range(0, waddrs.size() - 1)];
        n = $urandom_range(1, 3);
        do_rread(a, n, acks);
        chk($sformatf("rnd%0d_rr_acks", t), 32'(acks), 32'd3);
        check_reads($sformatf("rnd%0d", t), a, n);
      end else begin
        a = mptr;
        n = $urandom_range(1, 2);
        do_cread(a[10:8], n, acks);
        chk($sformatf("rnd%0d_cr_acks", t), 32'(acks), 32'd1);
        check_reads($sformatf("rnd%0d", t), a, n);
      end
      chk($sformatf("rnd%0d_busy_after_stop", t), 32'(BUSY), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
